// File: rtl/branch_predict_resolve_pkg.sv
// Shared branch-unit definitions: funct3 branch encodings, BHT counter reset value
// and the 2-bit saturating counter update.
package branch_predict_resolve_pkg;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_JUMP = 3'b010,
    OP_RSVD = 3'b011,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } branch_op_e;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;

  // Only conditional branches train the predictor.
  function automatic logic is_conditional(branch_op_e op);
    return (op != OP_JUMP) && (op != OP_RSVD);
  endfunction

  function automatic logic [1:0] ctr_next(logic [1:0] ctr, logic taken);
    if (taken) return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    else       return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Lookup/resolve request and response bundle for the branch predict/resolve unit.
interface branch_predict_resolve_if #(
  parameter int unsigned XLEN = 32
);
  logic            pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic            pred_out_valid;
  logic            pred_taken;

  logic            res_valid;
  logic [2:0]      branch_op;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            res_pred_taken;
  logic            redirect;
  logic [XLEN-1:0] new_addr;
  logic            taken;
  logic [15:0]     mispredict_count;

  modport master (
    output pred_valid, pred_pc, res_valid, branch_op, res_pc, immediate, rs1, rs2,
           res_pred_taken,
    input  pred_out_valid, pred_taken, redirect, new_addr, taken, mispredict_count
  );

  modport slave (
    input  pred_valid, pred_pc, res_valid, branch_op, res_pc, immediate, rs1, rs2,
           res_pred_taken,
    output pred_out_valid, pred_taken, redirect, new_addr, taken, mispredict_count
  );
endinterface

// File: rtl/branch_predict_resolve_bht_counters.sv
// Branch history table: array of 2-bit saturating counters with one combinational
// read port (returns pre-update value) and one write port.
module bht_counters
  import branch_predict_resolve_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr_c,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_q [DEPTH];

  assign rd_ctr_c = ctr_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ctr_q[i] <= CTR_RESET;
    end else if (wr_en) begin
      ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch predict/resolve unit: BHT lookup for fetch, branch condition and target
// evaluation for resolve, redirect generation and mispredict statistics.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64
) (
  input logic                     clk,
  input logic                     rst,
  branch_predict_resolve_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] pred_idx_c;
  logic [IDX_W-1:0] res_idx_c;
  logic [1:0]       rd_ctr_c;
  branch_op_e       op_c;
  logic             eq_c, lt_s_c, lt_u_c;
  logic             actual_c;
  logic             redirect_c;
  logic [XLEN-1:0]  target_c;
  logic [XLEN-1:0]  seq_c;
  logic [XLEN-1:0]  addr_c;
  logic             unused_pc_bits;

  logic             pred_out_valid_q;
  logic             pred_taken_q;
  logic             redirect_q;
  logic             taken_q;
  logic [XLEN-1:0]  new_addr_q;
  logic [15:0]      mispredict_count_q;

  assign pred_idx_c = bus.pred_pc[IDX_W+1:2];
  assign res_idx_c  = bus.res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.pred_pc[XLEN-1:IDX_W+2], bus.pred_pc[1:0],
                            bus.res_pc[XLEN-1:IDX_W+2], bus.res_pc[1:0]};

  bht_counters #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pred_idx_c),
    .rd_ctr_c (rd_ctr_c),
    .wr_en    (bus.res_valid && is_conditional(op_c)),
    .wr_idx   (res_idx_c),
    .wr_taken (actual_c)
  );

  // Branch condition, target and fall-through address.
  always_comb begin
    op_c     = branch_op_e'(bus.branch_op);
    eq_c     = (bus.rs1 == bus.rs2);
    lt_s_c   = ($signed(bus.rs1) < $signed(bus.rs2));
    lt_u_c   = (bus.rs1 < bus.rs2);
    target_c = bus.res_pc + bus.immediate;
    seq_c    = bus.res_pc + XLEN'(4);
    actual_c = 1'b0;
    case (op_c)
      OP_BEQ:  actual_c = eq_c;
      OP_BNE:  actual_c = !eq_c;
      OP_BLT:  actual_c = lt_s_c;
      OP_BGE:  actual_c = !lt_s_c;
      OP_BLTU: actual_c = lt_u_c;
      OP_BGEU: actual_c = !lt_u_c;
      OP_JUMP: actual_c = 1'b1;
      default: actual_c = 1'b0;
    endcase
    // The reserved op never redirects regardless of what was predicted.
    redirect_c = bus.res_valid && (op_c != OP_RSVD) && (actual_c != bus.res_pred_taken);
    addr_c     = actual_c ? target_c : seq_c;
  end

  // Registered prediction and resolution outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_out_valid_q   <= 1'b0;
      pred_taken_q       <= 1'b0;
      redirect_q         <= 1'b0;
      taken_q            <= 1'b0;
      new_addr_q         <= '0;
      mispredict_count_q <= '0;
    end else begin
      pred_out_valid_q <= bus.pred_valid;
      pred_taken_q     <= bus.pred_valid && rd_ctr_c[1];
      redirect_q       <= redirect_c;
      taken_q          <= bus.res_valid && actual_c;
      new_addr_q       <= bus.res_valid ? addr_c : '0;
      if (redirect_c && (mispredict_count_q != 16'hFFFF))
        mispredict_count_q <= mispredict_count_q + 16'd1;
    end
  end

  assign bus.pred_out_valid   = pred_out_valid_q;
  assign bus.pred_taken       = pred_taken_q;
  assign bus.redirect         = redirect_q;
  assign bus.taken            = taken_q;
  assign bus.new_addr         = new_addr_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench for branch_predict_resolve: directed lookups/resolves push
// expected responses; a negedge monitor pops and compares.
module tb_branch_predict_resolve;
  import branch_predict_resolve_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predict_resolve_if #(.XLEN(32)) bus ();

  branch_predict_resolve #(.XLEN(32), .BHT_DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        redirect;
    logic        taken;
    logic [31:0] new_addr;
    logic [15:0] count;
  } res_exp_t;

  bit       pred_q[$];
  res_exp_t res_q[$];
  int       checks = 0;
  int       passed = 0;
  bit       pred_due = 0;
  bit       res_due  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic lookup(input logic [31:0] pc, input bit exp_taken);
    bus.pred_valid = 1'b1;
    bus.pred_pc    = pc;
    pred_q.push_back(exp_taken);
  endtask

  task automatic resolve(input branch_op_e op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input bit pt,
                         input bit e_red, input bit e_tk, input logic [31:0] e_addr,
                         input logic [15:0] e_cnt);
    res_exp_t e;
    bus.res_valid      = 1'b1;
    bus.branch_op      = op;
    bus.res_pc         = pc;
    bus.immediate      = imm;
    bus.rs1            = a;
    bus.rs2            = b;
    bus.res_pred_taken = pt;
    e.redirect = e_red; e.taken = e_tk; e.new_addr = e_addr; e.count = e_cnt;
    res_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
  endtask

  // Note which requests the DUT accepted on this edge.
  always @(posedge clk) begin
    pred_due = bus.pred_valid && !rst;
    res_due  = bus.res_valid && !rst;
  end

  always @(negedge clk) begin
    bit       ep;
    res_exp_t er;
    if (!rst) begin
      if (pred_due) begin
        if (pred_q.size() == 0) begin
          checks++;
          $display("FAIL pred_unexpected: got response with empty queue at %0t", $time);
        end else begin
          ep = pred_q.pop_front();
          check("pred_out_valid", 32'(bus.pred_out_valid), 32'd1);
          check("pred_taken", 32'(bus.pred_taken), 32'(ep));
        end
      end else begin
        check("pred_idle", 32'({bus.pred_out_valid, bus.pred_taken}), 32'd0);
      end
      if (res_due) begin
        if (res_q.size() == 0) begin
          checks++;
          $display("FAIL res_unexpected: got response with empty queue at %0t", $time);
        end else begin
          er = res_q.pop_front();
          check("redirect", 32'(bus.redirect), 32'(er.redirect));
          check("taken", 32'(bus.taken), 32'(er.taken));
          check("new_addr", bus.new_addr, er.new_addr);
          check("mispredict_count", 32'(bus.mispredict_count), 32'(er.count));
        end
      end else begin
        check("res_idle", 32'({bus.redirect, bus.taken}), 32'd0);
        check("res_idle_addr", bus.new_addr, 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_pred_out_valid"}, 32'(bus.pred_out_valid), 32'd0);
    check({tag, "_pred_taken"}, 32'(bus.pred_taken), 32'd0);
    check({tag, "_redirect"}, 32'(bus.redirect), 32'd0);
    check({tag, "_taken"}, 32'(bus.taken), 32'd0);
    check({tag, "_new_addr"}, bus.new_addr, 32'd0);
    check({tag, "_count"}, 32'(bus.mispredict_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.pred_valid = 1'b0; bus.pred_pc = '0;
    bus.res_valid = 1'b0; bus.branch_op = 3'b000; bus.res_pc = '0;
    bus.immediate = '0; bus.rs1 = '0; bus.rs2 = '0; bus.res_pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Fresh counters are weakly not-taken.
    lookup(32'h100, 1'b0); step();
    resolve(OP_BLT,  32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 32'h240, 16'd1); step();
    resolve(OP_BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b0, 32'h204, 16'd2); step();

    // Back-to-back taken BEQs train index 0 up to saturation.
    for (int i = 0; i < 3; i++) begin
      resolve(OP_BEQ, 32'h100, 32'h10, 32'h5, 32'h5, 1'b1, 1'b0, 1'b1, 32'h110, 16'd2); step();
    end
    lookup(32'h100, 1'b1); step();
    resolve(OP_BEQ, 32'h100, 32'h10, 32'h5, 32'h5, 1'b1, 1'b0, 1'b1, 32'h110, 16'd2); step();
    lookup(32'h100, 1'b1); step();
    resolve(OP_BEQ, 32'h100, 32'h10, 32'h5, 32'h6, 1'b1, 1'b1, 1'b0, 32'h104, 16'd3); step();
    lookup(32'h100, 1'b1); step();
    resolve(OP_BEQ, 32'h100, 32'h10, 32'h5, 32'h6, 1'b0, 1'b0, 1'b0, 32'h104, 16'd3); step();
    lookup(32'h100, 1'b0); step();

    // Same-cycle lookup and update at index 5 sees the old counter.
    lookup(32'h14, 1'b0);
    resolve(OP_BNE, 32'h14, 32'h8, 32'h1, 32'h2, 1'b1, 1'b0, 1'b1, 32'h1C, 16'd3); step();
    lookup(32'h14, 1'b1); step();

    // Jump wraps the target and leaves index 60 untouched.
    resolve(OP_JUMP, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 16'd4); step();
    lookup(32'hFFFF_FFF0, 1'b0); step();
    resolve(OP_RSVD, 32'h14, 32'h8, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0, 32'h18, 16'd4); step();
    lookup(32'h14, 1'b1); step();

    resolve(OP_BGE,  32'h300, 32'h80, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h304, 16'd4); step();
    resolve(OP_BGEU, 32'h300, 32'h80, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 32'h380, 16'd5); step();
    resolve(OP_BNE,  32'h40, 32'h100, 32'h7, 32'h7, 1'b0, 1'b0, 1'b0, 32'h44, 16'd5); step();
    resolve(OP_BEQ,  32'h1000, 32'hFFFF_FFF0, 32'h3, 32'h3, 1'b1, 1'b0, 1'b1, 32'hFF0, 16'd5); step();

    // Reset lands while a mispredict and a lookup are being presented.
    lookup(32'h14, 1'b1);
    resolve(OP_BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 32'h240, 16'd6);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    pred_q.delete();
    res_q.delete();
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();

    lookup(32'h14, 1'b0); step();
    resolve(OP_BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 32'h240, 16'd1); step();
    repeat (3) step();

    check("pred_q_drained", 32'(pred_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/address width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit counters (power of two, >=2).
REQ-003 SHALL have ports clk input 1 (clock), then rst input 1 (reset); one clock, reset asynchronous and active-high.
REQ-004 SHALL have ports pred_valid input 1 (lookup request) and pred_pc input XLEN (fetch PC).
REQ-005 SHALL have ports pred_out_valid output 1 and pred_taken output 1 (registered prediction).
REQ-006 SHALL have ports res_valid input 1 (resolve request), branch_op input 3 (funct3 encoding; 3'b010 = jump), res_pc input XLEN, immediate input XLEN, rs1 input XLEN, rs2 input XLEN, res_pred_taken input 1 (prediction carried down the pipe).
REQ-007 SHALL have ports redirect output 1, new_addr output XLEN, taken output 1 (registered resolution).
REQ-008 SHALL have port mispredict_count output 16, a saturating statistics counter.

Function
REQ-009 SHALL index the BHT with pred_pc/res_pc bits [log2(BHT_DEPTH)+1:2].
REQ-010 SHALL register pred_taken = counter[1] of the indexed entry one cycle after pred_valid, with pred_out_valid high for exactly that cycle.
REQ-011 SHALL evaluate branch_op: 000 BEQ rs1==rs2; 001 BNE rs1!=rs2; 100 BLT signed rs1<rs2; 101 BGE signed rs1>=rs2; 110 BLTU unsigned <; 111 BGEU unsigned >=; 010 always taken; 011 never taken, no redirect, no BHT update.
REQ-012 SHALL compute target = res_pc + immediate, modulo 2^XLEN (wrap, no overflow flag).
REQ-013 SHALL assert redirect one cycle after res_valid when the actual outcome differs from res_pred_taken; new_addr = target if taken, else res_pc + 4.
REQ-014 SHALL drive taken with the registered actual outcome; redirect, taken and new_addr hold zero in cycles without a resolve.
REQ-015 SHALL update the indexed counter on res_valid for conditional ops only: taken increments, not-taken decrements, saturating at 2'b11 and 2'b00.
REQ-016 SHALL leave the BHT unchanged for the jump op (010) and reserved op 011.
REQ-017 SHALL return the pre-update counter value when a lookup and an update hit the same index in the same cycle.
REQ-018 SHALL increment mispredict_count on each registered redirect, saturating at 16'hFFFF.
REQ-019 SHALL accept back-to-back resolves, one per cycle, with no stall.

Reset
REQ-020 SHALL, when rst is high, asynchronously set every BHT counter to 2'b01 (weakly not-taken).
REQ-021 SHALL hold pred_out_valid, pred_taken, redirect, taken, new_addr and mispredict_count at zero during reset.
REQ-022 SHALL discard any lookup or resolve in flight when reset is asserted; no output pulses after rst deasserts until a new request arrives.

Structure
REQ-023 SHALL take branch_op encodings (BEQ, BNE, JUMP, RSVD, BLT, BGE, BLTU, BGEU) and the counter reset value from the shared core package.
REQ-024 SHALL place the counter array with its saturating update in one sub-module, bht_counters (read port, write port, reset).
REQ-025 SHALL keep comparison and target arithmetic in the top module as combinational logic feeding the output registers.

Verification
REQ-026 SHALL cover reset then lookup pred_pc=0x100 -> pred_out_valid=1, pred_taken=0 one cycle later.
REQ-027 SHALL cover BLT with rs1=0xFFFFFFFF, rs2=1, res_pc=0x200, imm=0x40, res_pred_taken=0 -> redirect=1, taken=1, new_addr=0x240, mispredict_count=1.
REQ-028 SHALL cover BLTU with the same operands and res_pred_taken=1 -> taken=0, redirect=1, new_addr=0x204.
REQ-029 SHALL cover three taken BEQ resolves at pc 0x100 then a lookup of 0x100 -> pred_taken=1, and a fourth taken resolve leaves the counter saturated at 2'b11.
REQ-030 SHALL cover a same-cycle lookup and resolve at index 5 with counter 01, resolve taken -> lookup returns 0, and a following lookup returns 1.
REQ-031 SHALL cover a jump op with res_pc=0xFFFFFFF0, imm=0x20, res_pred_taken=0 -> new_addr=0x00000010, BHT unchanged, and rst asserted mid-stream -> all outputs zero.
